ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte from the FPGA to the keyboard, for example LED set (0xED) or reset (0xFF).
- Shares the open-collector PS2C/PS2D lines with the existing PS/2 receiver.
- The top level builds the tristates: pin driven low when *_oe=1, released (pulled up) otherwise.
- Reports completion and the device ACK so control logic can sequence multi-byte commands.

---
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter on open-collector PS2C/PS2D.
// Define PS2_TX_FILTER_EN to debounce synced PS2C before edge detection.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
`ifdef PS2_TX_FILTER_EN
  parameter int FILTER_LEN     = 8,
`endif
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_DATA,
    S_ACK, S_WAIT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  frame_q, frame_d;
  logic        pd_q, pd_d;
  logic        nack_q, nack_d;
  logic        busy_q;
  logic        c_s1_q, c_s2_q, d_s1_q, d_s2_q;
  logic        c_prev_q, c_lvl, fe, watch, tmo;

  // Lines idle high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1_q <= 1'b1;
      c_s2_q <= 1'b1;
      d_s1_q <= 1'b1;
      d_s2_q <= 1'b1;
    end else begin
      c_s1_q <= ps2c_in;
      c_s2_q <= c_s1_q;
      d_s1_q <= ps2d_in;
      d_s2_q <= d_s1_q;
    end
  end

`ifdef PS2_TX_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          cf_q;
  logic [FW-1:0] fc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cf_q <= 1'b1;
      fc_q <= '0;
    end else if (c_s2_q == cf_q) begin
      fc_q <= '0;
    end else if (fc_q == FW'(FILTER_LEN - 1)) begin
      cf_q <= c_s2_q;
      fc_q <= '0;
    end else begin
      fc_q <= fc_q + 1'b1;
    end
  end

  assign c_lvl = cf_q;
`else
  assign c_lvl = c_s2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) c_prev_q <= 1'b1;
    else     c_prev_q <= c_lvl;
  end

  assign fe    = c_prev_q & ~c_lvl;
  assign watch = (state_q == S_RTS) || (state_q == S_DATA) ||
                 (state_q == S_ACK) || (state_q == S_WAIT);
  assign tmo   = (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    pd_d    = pd_q;
    nack_d  = nack_q;
    unique case (state_q)
      S_IDLE: begin
        if (tx_start && !busy_q) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          cnt_d   = '0;
          idx_d   = '0;
          nack_d  = 1'b0;
          pd_d    = 1'b0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_q + 32'd1;
        // Start bit goes low one cycle before the clock is released.
        if (cnt_q == 32'(INHIBIT_CYCLES - 2)) pd_d = 1'b1;
        if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RTS;
        end
      end
      S_RTS: begin
        if (fe) begin
          pd_d    = ~frame_q[0];
          idx_d   = 4'd1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fe) begin
          pd_d  = ~frame_q[idx_q];
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd9) begin
            pd_d    = 1'b0;
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fe) begin
          nack_d  = d_s2_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (c_lvl && d_s2_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (watch) begin
      if (fe) begin
        cnt_d = '0;
      end else if (tmo) begin
        cnt_d   = '0;
        pd_d    = 1'b0;
        nack_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      pd_q    <= 1'b0;
      nack_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      pd_q    <= pd_d;
      nack_q  <= nack_d;
      busy_q  <= (state_d != S_IDLE) || (state_q == S_DONE);
    end
  end

  assign tx_busy = busy_q;
  assign tx_done = (state_q == S_DONE);
  assign tx_err  = (state_q == S_DONE) && nack_q;
  assign ps2c_oe = (state_q == S_INHIBIT);
  assign ps2d_oe = pd_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model
// and a scoreboard of expected on-wire frames.
module tb_ps2_host_tx;

  localparam int HALF = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int done_cnt = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  assign ps2c_in = ~ps2c_oe & dev_c;
  assign ps2d_in = ~ps2d_oe & dev_d;

  always @(posedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  ps2_host_tx #(
    .INHIBIT_CYCLES(100),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    int   ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = ((ones % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic wait_release(output int n, output int dcnt);
    n = 0;
    dcnt = 0;
    while (ps2c_oe === 1'b1 && n < 1000) begin
      if (ps2d_oe === 1'b1) dcnt++;
      tick();
      n++;
    end
  endtask

  task automatic dev_frame(input int nedges, input bit nack,
                           output logic [10:0] got);
    got = '1;
    got[0] = ps2d_in;
    repeat (HALF) tick();
    for (int i = 1; i <= 10 && i <= nedges; i++) begin
      dev_c = 1'b0;
      repeat (HALF) tick();
      dev_c = 1'b1;
      got[i] = ps2d_in;
      repeat (HALF) tick();
    end
    if (nedges >= 11) begin
      if (!nack) dev_d = 1'b0;
      repeat (20) tick();
      dev_c = 1'b0;
      repeat (HALF) tick();
      dev_c = 1'b1;
      dev_d = 1'b1;
    end
  endtask

  task automatic wait_done(input string tag, input bit exp_err);
    int k = 0;
    while (tx_done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, 32'(tx_done), 32'd1);
    chk({tag, "_err"}, 32'(tx_err), 32'(exp_err));
    chk({tag, "_c_oe"}, 32'(ps2c_oe), 32'd0);
    chk({tag, "_d_oe"}, 32'(ps2d_oe), 32'd0);
    tick();
    chk({tag, "_busy_hold"}, 32'(tx_busy), 32'd1);
    tick();
    chk({tag, "_busy_fall"}, 32'(tx_busy), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d,
                           input bit nack);
    int n, dc;
    logic [10:0] got;
    start_tx(d);
    exp_q.push_back(mk_frame(d));
    wait_release(n, dc);
    dev_frame(11, nack, got);
    chk({tag, "_frame"}, 32'(got), 32'(exp_q.pop_front()));
    wait_done(tag, nack);
  endtask

  initial begin
    int n, dc, k, d0;
    logic [10:0] got;

    repeat (3) tick();
    chk("rst_c_oe", 32'(ps2c_oe), 32'd0);
    chk("rst_d_oe", 32'(ps2d_oe), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // LED-set command with inhibit timing checked on the way
    start_tx(8'hED);
    exp_q.push_back(mk_frame(8'hED));
    chk("ed_busy", 32'(tx_busy), 32'd1);
    wait_release(n, dc);
    chk("ed_inhibit_len", 32'(n), 32'd100);
    chk("ed_start_lead", 32'(dc), 32'd1);
    chk("ed_start_bit", 32'(ps2d_oe), 32'd1);
    dev_frame(11, 1'b0, got);
    chk("ed_frame", 32'(got), 32'(exp_q.pop_front()));
    wait_done("ed", 1'b0);

    run_frame("p00", 8'h00, 1'b0);
    run_frame("p01", 8'h01, 1'b0);
    run_frame("pff", 8'hFF, 1'b0);
    run_frame("p80", 8'h80, 1'b0);

    run_frame("nack", 8'hF0, 1'b1);

    // device never clocks after request-to-send
    start_tx(8'h12);
    wait_release(n, dc);
    k = 0;
    while (tx_done !== 1'b1 && k < 3000) begin
      tick();
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'd2000);
    chk("tmo_done", 32'(tx_done), 32'd1);
    chk("tmo_err", 32'(tx_err), 32'd1);
    chk("tmo_d_oe", 32'(ps2d_oe), 32'd0);
    chk("tmo_c_oe", 32'(ps2c_oe), 32'd0);
    repeat (2) tick();
    chk("tmo_idle", 32'(tx_busy), 32'd0);

    // reset while the fourth data bit is on the wire
    start_tx(8'hA5);
    wait_release(n, dc);
    dev_frame(4, 1'b0, got);
    chk("rmid_d_driven", 32'(ps2d_oe), 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    chk("rmid_c_oe", 32'(ps2c_oe), 32'd0);
    chk("rmid_d_oe", 32'(ps2d_oe), 32'd0);
    chk("rmid_busy", 32'(tx_busy), 32'd0);
    rst = 1'b0;
    repeat (2500) tick();
    chk("rmid_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame("post_rst", 8'hFF, 1'b0);

    // second start while busy must not disturb the frame
    d0 = done_cnt;
    start_tx(8'hF4);
    exp_q.push_back(mk_frame(8'hF4));
    fork
      begin
        wait_release(n, dc);
        dev_frame(11, 1'b0, got);
      end
      begin
        repeat (50) tick();
        start_tx(8'h55);
        repeat (2000) tick();
        start_tx(8'h55);
        tx_data = 8'h00;
      end
    join
    chk("busy_frame", 32'(got), 32'(exp_q.pop_front()));
    wait_done("busy", 1'b0);
    repeat (3000) tick();
    chk("busy_one_done", 32'(done_cnt - d0), 32'd1);
    chk("busy_idle", 32'(tx_busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
